// File: rtl/divmod_if.sv
// Request/result bundle for the sequential divider.
// The master drives go/a/b; the slave returns ready/done/error/quot/rem.
interface divmod_if #(
  parameter int unsigned WIDTH_LOG = 4
);
  localparam int unsigned WIDTH = 1 << WIDTH_LOG;

  logic             go;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (output go, a, b, input ready, done, error, quot, rem);
  modport slave  (input go, a, b, output ready, done, error, quot, rem);
endinterface

// File: rtl/divmod.sv
// Unsigned restoring divider whose iteration count is set by the
// difference of the operands' leading-one positions.
module prio_enc #(
  parameter int unsigned WIDTH_LOG = 4
) (
  input  logic [(1 << WIDTH_LOG)-1:0] value,
  output logic [7:0]                  msb
);
  localparam int unsigned WIDTH = 1 << WIDTH_LOG;

  // Highest set bit wins; an all-zero value reports position 0.
  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) msb = 8'(i);
    end
  end
endmodule

module divmod #(
  parameter int unsigned WIDTH_LOG = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  divmod_if.slave bus
);
  localparam int unsigned WIDTH = 1 << WIDTH_LOG;

  typedef enum logic {IDLE, DIV} state_t;

  state_t               state;
  logic                 ready;
  logic                 done;
  logic                 error;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     d;
  logic [WIDTH_LOG-1:0] cnt;

  logic [7:0]           ma;
  logic [7:0]           mb;
  logic [WIDTH_LOG-1:0] shift;

  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_a (.value(bus.a), .msb(ma));
  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_b (.value(bus.b), .msb(mb));

  // Only reached when a >= b > 0, so ma >= mb and the low bits suffice.
  assign shift = WIDTH_LOG'(ma - mb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      error <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      d     <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            if (bus.b == '0) begin
              error <= 1'b1;
              quot  <= '0;
              rem   <= bus.a;
              done  <= 1'b1;
            end else if (bus.a < bus.b) begin
              error <= 1'b0;
              quot  <= '0;
              rem   <= bus.a;
              done  <= 1'b1;
            end else begin
              error <= 1'b0;
              quot  <= '0;
              rem   <= bus.a;
              d     <= bus.b << shift;
              cnt   <= shift;
              ready <= 1'b0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          // One quotient bit per cycle, divisor walking back toward bit 0.
          if (rem >= d) begin
            rem  <= rem - d;
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          d <= d >> 1;
          if (cnt == '0) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - WIDTH_LOG'(1);
          end
        end
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.error = error;
  assign bus.quot  = quot;
  assign bus.rem   = rem;
endmodule

// File: tb/tb_divmod.sv
// Self-checking bench for divmod: scoreboard of expected results pushed at
// each request and popped when the divider reports done.
module tb_divmod;
  localparam int unsigned WIDTH_LOG = 4;
  localparam int unsigned WIDTH = 1 << WIDTH_LOG;
  localparam int MAX_WAIT = 40;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             e;
  } result_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  result_t sb[$];

  divmod_if #(.WIDTH_LOG(WIDTH_LOG)) bus ();
  divmod #(.WIDTH_LOG(WIDTH_LOG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from the bench's own arithmetic.
  function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    result_t res;
    if (b == '0) begin
      res.q = '0; res.r = a; res.e = 1'b1;
    end else begin
      res.q = a / b; res.r = a % b; res.e = 1'b0;
    end
    return res;
  endfunction

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.go = 1'b1;
    bus.a  = a;
    bus.b  = b;
    sb.push_back(model(a, b));
  endtask

  // Drop go, then count negedges with ready low until ready returns.
  task automatic wait_ready(output int busy);
    @(negedge clk);
    bus.go = 1'b0;
    busy = 0;
    while (bus.ready !== 1'b1 && busy < MAX_WAIT) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    bus.go = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.ready, bus.done, bus.error, bus.quot, bus.rem} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b done=%b error=%b quot=%0d rem=%0d, want 1 0 0 0 0",
               bus.ready, bus.done, bus.error, bus.quot, bus.rem);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_and_check(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input int exp_busy);
    int busy;
    result_t exp;
    start_op(a, b);
    wait_ready(busy);
    exp = sb.pop_front();
    tests_run++;
    if (busy !== exp_busy) begin
      tests_failed++;
      $display("FAIL %s_latency: busy=%0d, want %0d", name, busy, exp_busy);
    end
    tests_run++;
    if ({bus.quot, bus.rem, bus.error, bus.done} !== {exp.q, exp.r, exp.e, 1'b1}) begin
      tests_failed++;
      $display("FAIL %s_result: quot=%0d rem=%0d error=%b done=%b, want %0d %0d %b 1",
               name, bus.quot, bus.rem, bus.error, bus.done, exp.q, exp.r, exp.e);
    end
  endtask

  task automatic test_normal();
    run_and_check("normal_100_7", 16'd100, 16'd7, 5);
    @(negedge clk);
    tests_run++;
    if ({bus.done, bus.ready, bus.quot, bus.rem} !== {1'b0, 1'b1, 16'd14, 16'd2}) begin
      tests_failed++;
      $display("FAIL done_pulse_hold: done=%b ready=%b quot=%0d rem=%0d, want 0 1 14 2",
               bus.done, bus.ready, bus.quot, bus.rem);
    end
  endtask

  task automatic test_max_latency();
    run_and_check("max_latency", 16'hFFFF, 16'd1, 16);
  endtask

  task automatic test_equal_msb();
    run_and_check("equal_msb", 16'h8000, 16'h8000, 1);
  endtask

  task automatic test_fast_paths();
    logic [WIDTH-1:0] ta[4] = '{16'd5, 16'd0, 16'd42, 16'd42};
    logic [WIDTH-1:0] tb[4] = '{16'd9, 16'd3, 16'd0,  16'd5};
    int               tl[4] = '{0, 0, 0, 4};
    for (int i = 0; i < 4; i++) begin
      run_and_check($sformatf("fast%0d", i), ta[i], tb[i], tl[i]);
    end
  endtask

  task automatic test_handshake();
    int busy;
    result_t exp;
    start_op(16'd1000, 16'd3);
    @(negedge clk);
    bus.a = 16'd7;
    bus.b = 16'd7;
    busy = 0;
    while (bus.ready !== 1'b1 && busy < MAX_WAIT) begin
      busy++;
      @(negedge clk);
    end
    exp = sb.pop_front();
    tests_run++;
    if (busy !== 9) begin
      tests_failed++;
      $display("FAIL hs_ignored_go_latency: busy=%0d, want 9", busy);
    end
    tests_run++;
    if ({bus.quot, bus.rem, bus.error, bus.done} !== {exp.q, exp.r, exp.e, 1'b1}) begin
      tests_failed++;
      $display("FAIL hs_first_result: quot=%0d rem=%0d error=%b done=%b, want %0d %0d %b 1",
               bus.quot, bus.rem, bus.error, bus.done, exp.q, exp.r, exp.e);
    end
    // New request issued in the done cycle itself.
    bus.a = 16'd9;
    bus.b = 16'd4;
    sb.push_back(model(16'd9, 16'd4));
    wait_ready(busy);
    exp = sb.pop_front();
    tests_run++;
    if (busy !== 2) begin
      tests_failed++;
      $display("FAIL hs_back_to_back_latency: busy=%0d, want 2", busy);
    end
    tests_run++;
    if ({bus.quot, bus.rem, bus.error, bus.done} !== {exp.q, exp.r, exp.e, 1'b1}) begin
      tests_failed++;
      $display("FAIL hs_back_to_back_result: quot=%0d rem=%0d error=%b done=%b, want %0d %0d %b 1",
               bus.quot, bus.rem, bus.error, bus.done, exp.q, exp.r, exp.e);
    end
  endtask

  task automatic test_reset_abort();
    result_t dropped;
    start_op(16'hFFFF, 16'd1);
    @(negedge clk);
    bus.go = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy_before_reset: ready=%b, want 0", bus.ready);
    end
    rst_n = 1'b0;
    #1;
    dropped = sb.pop_front();
    tests_run++;
    if ({bus.ready, bus.done, bus.error, bus.quot, bus.rem} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      tests_failed++;
      $display("FAIL abort_reset_values: ready=%b done=%b error=%b quot=%0d rem=%0d, want 1 0 0 0 0 (dropped q=%0d)",
               bus.ready, bus.done, bus.error, bus.quot, bus.rem, dropped.q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("after_abort", 16'd20, 16'd6, 3);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_normal();
    test_max_latency();
    test_equal_msb();
    test_fast_paths();
    test_handshake();
    test_reset_abort();
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/divmod.md
# divmod

Sequential unsigned divider producing quotient and remainder of two WIDTH-bit operands. It sits directly downstream of the priority encoder: two `prio_enc` instances give the leading-one positions of dividend and divisor. Their difference sets the initial divisor alignment and the iteration count, so a division costs (msb(a) − msb(b) + 1) cycles instead of a fixed WIDTH. The primality-test datapath uses it for trial-division remainders.

## Interface
- WIDTH_LOG, 4, log2 of operand width; WIDTH = 1 << WIDTH_LOG; passed unchanged to both `prio_enc` instances
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- go  input  1  start request, sampled only while ready=1
- a  input  WIDTH  dividend, sampled on the go edge
- b  input  WIDTH  divisor, sampled on the go edge
- ready  output  1  idle and able to accept go; results valid while high
- done  output  1  one-cycle pulse: quot/rem/error just updated
- error  output  1  last accepted request had b=0
- quot  output  WIDTH  quotient
- rem  output  WIDTH  remainder

## Operation
- States: IDLE (ready=1), DIV (ready=0).
- Internal registers:
  - d: WIDTH-bit aligned divisor
  - cnt: WIDTH_LOG-bit remaining-iteration count
- ma = msb(a) and mb = msb(b) come combinationally from `prio_enc` on the live a/b inputs. Only the low WIDTH_LOG bits of the 8-bit msb are used. msb(0) = 0.
- IDLE with go=1, exactly one branch on that edge:
  - b == 0: error<=1, quot<=0, rem<=a, done<=1; stay IDLE.
  - a < b (full compare; this includes a=0): error<=0, quot<=0, rem<=a, done<=1; stay IDLE.
  - otherwise: s = ma − mb (0..WIDTH−1, never negative here). rem<=a, d<=b<<s, cnt<=s, quot<=0, error<=0; go to DIV, ready<=0.
- DIV, each cycle:
  - if rem >= d: rem<=rem−d, quot<={quot[WIDTH−2:0],1}; else quot<={quot[WIDTH−2:0],0}.
  - d<=d>>1.
  - if cnt==0: go to IDLE, ready<=1, done<=1; else cnt<=cnt−1.
- Widths:
  - b<<s never overflows WIDTH, because s ≤ WIDTH−1−mb.
  - rem−d never underflows, because it is guarded by the compare.
  - The final quotient fits in s+1 bits; higher bits stay 0.
- done is 0 in every cycle except the one following a result update.
- go while ready=0 is ignored: no queuing and no effect on the running division.
- a/b may change freely while busy; only the go-edge values matter.
- Outputs hold their last values until the next accepted go updates them.

## Timing
- Reset (asynchronous assert, synchronous release at the clk edge): state=IDLE, ready=1, done=0, error=0, quot=0, rem=0, d=0, cnt=0.
- Reset asserted mid-division aborts it; partial results are discarded and all outputs return to reset values.
- Fast paths (b=0, a<b): ready never drops. Results and done=1 appear in the cycle after the go edge.
- Normal path, go accepted at edge E0:
  - ready=0 from E0 through edge E(s+1).
  - At E(s+1): ready=1, done=1, final quot/rem visible.
  - Latency is s+1 cycles; 1 minimum (ma=mb), WIDTH maximum.
- Back-to-back: go may be asserted in the same cycle done=1 (ready=1). No dead cycle.
- Combinational paths: the `prio_enc` outputs and the a<b compare feed only register inputs. No input-to-output combinational path.

## Test plan
- Normal path: a=100, b=7, go one cycle.
  - Required: ma=6, mb=2, s=4; ready low exactly 5 cycles.
  - Then ready=1, done=1, quot=14, rem=2, error=0.
- Maximum latency: a=65535, b=1.
  - Required: ready low 16 cycles, then quot=65535, rem=0.
- Equal leading-one position: a=0x8000, b=0x8000.
  - Required: 1 cycle busy, quot=1, rem=0.
- Fast paths, each with ready staying 1 and done pulsing the next cycle:
  - a=5, b=9 -> quot=0, rem=5, error=0.
  - a=0, b=3 -> quot=0, rem=0, error=0.
  - a=42, b=0 -> error=1, quot=0, rem=42.
  - A following valid request (a=42, b=5) clears error and gives quot=8, rem=2.
- Handshake: start a=1000, b=3.
  - Hold go=1 with a=7, b=7 while busy; the extra go is ignored and the result is quot=333, rem=1.
  - Assert go with a=9, b=4 in the done cycle; required: accepted immediately, result quot=2, rem=1.
- Reset abort: start a=65535, b=1 and assert rst low after 5 busy cycles.
  - Required: outputs immediately at reset values (ready=1, quot=0, rem=0, error=0, done=0).
  - After release, a new request a=20, b=6 gives quot=3, rem=2.
